prefetch_ar_arbiter: RTL and testbench

Shares the single memory-side AXI read channel (AR + R) between the demand path (client requests forwarded unchanged) and the prefetch path (requests generated by the prefetch control path). It sits between those two request sources and the DRAM AXI slave. AR requests are arbitrated with demand priority and bounded prefetch starvation. Each returning R burst is routed back to the source that issued it, using an in-order tag FIFO.

---
 rtl/prefetch_ar_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_prefetch_ar_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_ar_arbiter.sv
// Shares one memory-side AXI read channel between the demand and prefetch sources.
// AR arbitration gives demand priority, with prefetch aging; R bursts return in issue order through a tag FIFO.
module prefetch_ar_arbiter #(
  parameter int ADDR_BITS       = 16,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_OUTSTANDING = 2,
  parameter int STARVE_WIDTH    = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       en,

  input  logic                       dmd_ar_valid,
  output logic                       dmd_ar_ready,
  input  logic [ADDR_BITS-1:0]       dmd_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] dmd_ar_len,
  input  logic [TID_WIDTH-1:0]       dmd_ar_id,

  input  logic                       pf_ar_valid,
  output logic                       pf_ar_ready,
  input  logic [ADDR_BITS-1:0]       pf_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] pf_ar_len,
  input  logic [TID_WIDTH-1:0]       pf_ar_id,

  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
  output logic [TID_WIDTH-1:0]       m_ar_id,

  input  logic                       m_r_valid,
  output logic                       m_r_ready,
  input  logic [DATA_WIDTH-1:0]      m_r_data,
  input  logic                       m_r_last,
  input  logic [TID_WIDTH-1:0]       m_r_id,

  output logic                       dmd_r_valid,
  input  logic                       dmd_r_ready,
  output logic [DATA_WIDTH-1:0]      dmd_r_data,
  output logic                       dmd_r_last,
  output logic [TID_WIDTH-1:0]       dmd_r_id,

  output logic                       pf_r_valid,
  input  logic                       pf_r_ready,
  output logic [DATA_WIDTH-1:0]      pf_r_data,
  output logic                       pf_r_last,
  output logic [TID_WIDTH-1:0]       pf_r_id,

  input  logic [STARVE_WIDTH-1:0]    crs_starveLimit,
  output logic [LOG_OUTSTANDING:0]   outstandingCnt,
  output logic                       errUnexpectedR
);

  localparam int DEPTH = 1 << LOG_OUTSTANDING;
  localparam logic [LOG_OUTSTANDING-1:0] PTR_ONE    = 1;
  localparam logic [LOG_OUTSTANDING:0]   CNT_ONE    = 1;
  localparam logic [STARVE_WIDTH-1:0]    STARVE_ONE = 1;

  logic                       m_ar_valid_q, m_ar_valid_d;
  logic [ADDR_BITS-1:0]       m_ar_addr_q, m_ar_addr_d;
  logic [BURST_LEN_WIDTH-1:0] m_ar_len_q, m_ar_len_d;
  logic [TID_WIDTH-1:0]       m_ar_id_q, m_ar_id_d;
  logic [STARVE_WIDTH-1:0]    starve_q, starve_d;
  logic [DEPTH-1:0]           tags_q, tags_d;
  logic [LOG_OUTSTANDING-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LOG_OUTSTANDING:0]   cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic slot_open, starve_hit, grant_pf, grant_dmd, push, pop;
  logic fifo_empty, route_dmd, route_pf;

  // Full is exactly cnt_q == DEPTH, i.e. the MSB of the occupancy count.
  always_comb begin
    slot_open  = resetN && en && (!m_ar_valid_q || m_ar_ready) && !cnt_q[LOG_OUTSTANDING];
    starve_hit = (crs_starveLimit != '0) && (starve_q >= crs_starveLimit);
    grant_pf   = slot_open && pf_ar_valid && (!dmd_ar_valid || starve_hit);
    grant_dmd  = slot_open && dmd_ar_valid && !grant_pf;
    push       = grant_pf || grant_dmd;

    dmd_ar_ready = grant_dmd;
    pf_ar_ready  = grant_pf;
  end

  always_comb begin
    fifo_empty = (cnt_q == '0);
    route_dmd  = resetN && !fifo_empty && !tags_q[rptr_q];
    route_pf   = resetN && !fifo_empty && tags_q[rptr_q];

    dmd_r_valid = route_dmd && m_r_valid;
    dmd_r_data  = route_dmd ? m_r_data : '0;
    dmd_r_last  = route_dmd && m_r_last;
    dmd_r_id    = route_dmd ? m_r_id : '0;
    pf_r_valid  = route_pf && m_r_valid;
    pf_r_data   = route_pf ? m_r_data : '0;
    pf_r_last   = route_pf && m_r_last;
    pf_r_id     = route_pf ? m_r_id : '0;

    // With nothing outstanding, beats are accepted and dropped so the slave never wedges.
    m_r_ready = (route_dmd && dmd_r_ready) || (route_pf && pf_r_ready) || (resetN && fifo_empty);
    pop       = m_r_valid && m_r_ready && m_r_last && !fifo_empty;
  end

  always_comb begin
    m_ar_valid_d = m_ar_valid_q;
    m_ar_addr_d  = m_ar_addr_q;
    m_ar_len_d   = m_ar_len_q;
    m_ar_id_d    = m_ar_id_q;
    if (grant_dmd) begin
      m_ar_valid_d = 1'b1;
      m_ar_addr_d  = dmd_ar_addr;
      m_ar_len_d   = dmd_ar_len;
      m_ar_id_d    = dmd_ar_id;
    end else if (grant_pf) begin
      m_ar_valid_d = 1'b1;
      m_ar_addr_d  = pf_ar_addr;
      m_ar_len_d   = pf_ar_len;
      m_ar_id_d    = pf_ar_id;
    end else if (m_ar_ready) begin
      m_ar_valid_d = 1'b0;
    end

    starve_d = starve_q;
    if (grant_pf) begin
      starve_d = '0;
    end else if (pf_ar_valid && !(&starve_q)) begin
      starve_d = starve_q + STARVE_ONE;
    end

    tags_d = tags_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      tags_d[wptr_q] = grant_pf;
      wptr_d         = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    err_d = err_q || (m_r_valid && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      m_ar_valid_q <= 1'b0;
      m_ar_addr_q  <= '0;
      m_ar_len_q   <= '0;
      m_ar_id_q    <= '0;
      starve_q     <= '0;
      tags_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      m_ar_valid_q <= m_ar_valid_d;
      m_ar_addr_q  <= m_ar_addr_d;
      m_ar_len_q   <= m_ar_len_d;
      m_ar_id_q    <= m_ar_id_d;
      starve_q     <= starve_d;
      tags_q       <= tags_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign m_ar_valid     = m_ar_valid_q;
  assign m_ar_addr      = m_ar_addr_q;
  assign m_ar_len       = m_ar_len_q;
  assign m_ar_id        = m_ar_id_q;
  assign outstandingCnt = cnt_q;
  assign errUnexpectedR = err_q;

endmodule

// File: tb/tb_prefetch_ar_arbiter.sv
// Directed bench for prefetch_ar_arbiter: AR arbitration, aging, fill/stall, R routing, error flag, enable and reset.
module tb_prefetch_ar_arbiter;

  logic        clk = 1'b0;
  logic        resetN, en;
  logic        dmd_ar_valid, dmd_ar_ready;
  logic [15:0] dmd_ar_addr;
  logic [7:0]  dmd_ar_len, dmd_ar_id;
  logic        pf_ar_valid, pf_ar_ready;
  logic [15:0] pf_ar_addr;
  logic [7:0]  pf_ar_len, pf_ar_id;
  logic        m_ar_valid, m_ar_ready;
  logic [15:0] m_ar_addr;
  logic [7:0]  m_ar_len, m_ar_id;
  logic        m_r_valid, m_r_ready, m_r_last;
  logic [7:0]  m_r_data, m_r_id;
  logic        dmd_r_valid, dmd_r_ready, dmd_r_last;
  logic [7:0]  dmd_r_data, dmd_r_id;
  logic        pf_r_valid, pf_r_ready, pf_r_last;
  logic [7:0]  pf_r_data, pf_r_id;
  logic [3:0]  crs_starveLimit;
  logic [2:0]  outstandingCnt;
  logic        errUnexpectedR;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prefetch_ar_arbiter dut (
    .clk(clk), .resetN(resetN), .en(en),
    .dmd_ar_valid(dmd_ar_valid), .dmd_ar_ready(dmd_ar_ready), .dmd_ar_addr(dmd_ar_addr),
    .dmd_ar_len(dmd_ar_len), .dmd_ar_id(dmd_ar_id),
    .pf_ar_valid(pf_ar_valid), .pf_ar_ready(pf_ar_ready), .pf_ar_addr(pf_ar_addr),
    .pf_ar_len(pf_ar_len), .pf_ar_id(pf_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
    .m_r_last(m_r_last), .m_r_id(m_r_id),
    .dmd_r_valid(dmd_r_valid), .dmd_r_ready(dmd_r_ready), .dmd_r_data(dmd_r_data),
    .dmd_r_last(dmd_r_last), .dmd_r_id(dmd_r_id),
    .pf_r_valid(pf_r_valid), .pf_r_ready(pf_r_ready), .pf_r_data(pf_r_data),
    .pf_r_last(pf_r_last), .pf_r_id(pf_r_id),
    .crs_starveLimit(crs_starveLimit), .outstandingCnt(outstandingCnt),
    .errUnexpectedR(errUnexpectedR)
  );

  // Inputs change just after the rising edge; checks follow one time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0; en = 1'b1; m_ar_ready = 1'b1; crs_starveLimit = 4'd0;
    dmd_ar_valid = 1'b1; dmd_ar_addr = 16'h1234; dmd_ar_len = 8'd0; dmd_ar_id = 8'd1;
    pf_ar_valid = 1'b1; pf_ar_addr = 16'h4321; pf_ar_len = 8'd0; pf_ar_id = 8'd2;
    m_r_valid = 1'b0; m_r_data = 8'h00; m_r_last = 1'b0; m_r_id = 8'h00;
    dmd_r_ready = 1'b1; pf_r_ready = 1'b1;
    tick(); tick();
    #1;
    n_tests++; if (m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_ar_valid got %0b exp 0", m_ar_valid); end
    n_tests++; if (m_ar_addr !== 16'h0) begin n_fail++; $display("FAIL reset_m_ar_addr got %0h exp 0", m_ar_addr); end
    n_tests++; if (outstandingCnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", outstandingCnt); end
    n_tests++; if (errUnexpectedR !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b exp 0", errUnexpectedR); end
    n_tests++; if (dmd_ar_ready !== 1'b0 || pf_ar_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ar_ready got %0b/%0b exp 0/0", dmd_ar_ready, pf_ar_ready); end
    n_tests++; if (m_r_ready !== 1'b0) begin n_fail++; $display("FAIL reset_m_r_ready got %0b exp 0", m_r_ready); end
    dmd_ar_valid = 1'b0; pf_ar_valid = 1'b0;
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_single_demand();
    dmd_ar_valid = 1'b1; dmd_ar_addr = 16'h0eef; dmd_ar_len = 8'd2; dmd_ar_id = 8'd5;
    #1;
    n_tests++; if (dmd_ar_ready !== 1'b1 || pf_ar_ready !== 1'b0) begin n_fail++; $display("FAIL single_ar_ready got %0b/%0b exp 1/0", dmd_ar_ready, pf_ar_ready); end
    tick();
    dmd_ar_valid = 1'b0;
    #1;
    n_tests++; if (m_ar_valid !== 1'b1) begin n_fail++; $display("FAIL single_m_ar_valid got %0b exp 1", m_ar_valid); end
    n_tests++; if (m_ar_addr !== 16'h0eef || m_ar_len !== 8'd2 || m_ar_id !== 8'd5) begin n_fail++; $display("FAIL single_payload got %0h/%0d/%0d exp 0eef/2/5", m_ar_addr, m_ar_len, m_ar_id); end
    n_tests++; if (outstandingCnt !== 3'd1) begin n_fail++; $display("FAIL single_cnt1 got %0d exp 1", outstandingCnt); end
    tick();
    n_tests++; if (m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL single_ar_consumed got %0b exp 0", m_ar_valid); end
    for (int i = 0; i < 3; i++) begin
      m_r_valid = 1'b1; m_r_data = 8'ha0 + 8'(i); m_r_last = (i == 2); m_r_id = 8'd5;
      #1;
      n_tests++; if (dmd_r_valid !== 1'b1 || pf_r_valid !== 1'b0) begin n_fail++; $display("FAIL single_beat%0d_valid got %0b/%0b exp 1/0", i, dmd_r_valid, pf_r_valid); end
      n_tests++; if (dmd_r_data !== 8'ha0 + 8'(i) || dmd_r_last !== (i == 2) || dmd_r_id !== 8'd5) begin n_fail++; $display("FAIL single_beat%0d_payload got %0h/%0b/%0d", i, dmd_r_data, dmd_r_last, dmd_r_id); end
      n_tests++; if (m_r_ready !== 1'b1) begin n_fail++; $display("FAIL single_beat%0d_m_r_ready got %0b exp 1", i, m_r_ready); end
      tick();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
    #1;
    n_tests++; if (outstandingCnt !== 3'd0) begin n_fail++; $display("FAIL single_cnt0 got %0d exp 0", outstandingCnt); end
  endtask

  task automatic test_starvation();
    logic [7:0] pat;
    pat = 8'b1000_1000;
    crs_starveLimit = 4'd3;
    dmd_r_ready = 1'b1; pf_r_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      dmd_ar_valid = 1'b1; pf_ar_valid = 1'b1;
      dmd_ar_addr = 16'h0100 + 16'(k); pf_ar_addr = 16'h0200 + 16'(k);
      dmd_ar_len = 8'd0; pf_ar_len = 8'd0;
      m_r_valid = (k > 0); m_r_last = 1'b1;
      #1;
      n_tests++; if (dmd_ar_ready !== !pat[k] || pf_ar_ready !== pat[k]) begin n_fail++; $display("FAIL starve_grant%0d got d%0b p%0b exp p%0b", k, dmd_ar_ready, pf_ar_ready, pat[k]); end
      if (k > 0) begin
        n_tests++; if (dmd_r_valid !== !pat[k-1] || pf_r_valid !== pat[k-1]) begin n_fail++; $display("FAIL starve_route%0d got d%0b p%0b exp p%0b", k, dmd_r_valid, pf_r_valid, pat[k-1]); end
      end
      tick();
    end
    dmd_ar_valid = 1'b0; pf_ar_valid = 1'b0; m_r_valid = 1'b1;
    #1;
    n_tests++; if (pf_r_valid !== 1'b1) begin n_fail++; $display("FAIL starve_route_last got %0b exp 1", pf_r_valid); end
    tick();
    crs_starveLimit = 4'd0;
    for (int k = 0; k < 6; k++) begin
      dmd_ar_valid = 1'b1; pf_ar_valid = 1'b1;
      m_r_valid = (k > 0); m_r_last = 1'b1;
      #1;
      n_tests++; if (dmd_ar_ready !== 1'b1 || pf_ar_ready !== 1'b0) begin n_fail++; $display("FAIL noage_grant%0d got d%0b p%0b exp d1 p0", k, dmd_ar_ready, pf_ar_ready); end
      tick();
    end
    dmd_ar_valid = 1'b0; pf_ar_valid = 1'b0; m_r_valid = 1'b1;
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    #1;
    n_tests++; if (outstandingCnt !== 3'd0) begin n_fail++; $display("FAIL starve_drain_cnt got %0d exp 0", outstandingCnt); end
  endtask

  task automatic test_fill_stall();
    m_ar_ready = 1'b1; m_r_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dmd_ar_valid = 1'b1; dmd_ar_addr = 16'h0300 + 16'(k); dmd_ar_len = 8'd0;
      tick();
    end
    #1;
    n_tests++; if (outstandingCnt !== 3'd4) begin n_fail++; $display("FAIL fill_cnt got %0d exp 4", outstandingCnt); end
    n_tests++; if (dmd_ar_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got %0b exp 0", dmd_ar_ready); end
    m_r_valid = 1'b1; m_r_last = 1'b1; dmd_r_ready = 1'b1;
    #1;
    n_tests++; if (dmd_ar_ready !== 1'b0) begin n_fail++; $display("FAIL fill_same_cycle_ready got %0b exp 0", dmd_ar_ready); end
    tick();
    m_r_valid = 1'b0;
    #1;
    n_tests++; if (outstandingCnt !== 3'd3 || dmd_ar_ready !== 1'b1) begin n_fail++; $display("FAIL fill_reopen got cnt %0d rdy %0b exp 3/1", outstandingCnt, dmd_ar_ready); end
    tick();
    dmd_ar_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_r_valid = 1'b1; m_r_last = 1'b1;
      tick();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
    #1;
    n_tests++; if (outstandingCnt !== 3'd0) begin n_fail++; $display("FAIL fill_drain_cnt got %0d exp 0", outstandingCnt); end
  endtask

  task automatic test_mixed_routing();
    logic [5:0] dst, lst, stl;
    dst = 6'b000100; lst = 6'b100110; stl = 6'b010010;
    m_ar_ready = 1'b1;
    dmd_ar_valid = 1'b1; dmd_ar_len = 8'd1; dmd_ar_id = 8'd11;
    tick();
    dmd_ar_valid = 1'b0; pf_ar_valid = 1'b1; pf_ar_len = 8'd0; pf_ar_id = 8'd22;
    tick();
    pf_ar_valid = 1'b0; dmd_ar_valid = 1'b1; dmd_ar_len = 8'd2; dmd_ar_id = 8'd33;
    tick();
    dmd_ar_valid = 1'b0;
    #1;
    n_tests++; if (outstandingCnt !== 3'd3) begin n_fail++; $display("FAIL mixed_cnt3 got %0d exp 3", outstandingCnt); end
    for (int i = 0; i < 6; i++) begin
      m_r_valid = 1'b1; m_r_data = 8'h10 + 8'(i); m_r_last = lst[i];
      if (stl[i]) begin
        dmd_r_ready = dst[i]; pf_r_ready = !dst[i];
        #1;
        n_tests++; if (m_r_ready !== 1'b0) begin n_fail++; $display("FAIL mixed_stall%0d m_r_ready got %0b exp 0", i, m_r_ready); end
        tick();
      end
      dmd_r_ready = 1'b1; pf_r_ready = 1'b1;
      #1;
      n_tests++; if (dmd_r_valid !== !dst[i] || pf_r_valid !== dst[i]) begin n_fail++; $display("FAIL mixed_route%0d got d%0b p%0b exp p%0b", i, dmd_r_valid, pf_r_valid, dst[i]); end
      n_tests++; if ((dst[i] ? pf_r_data : dmd_r_data) !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL mixed_data%0d got %0h/%0h exp %0h", i, dmd_r_data, pf_r_data, 8'h10 + 8'(i)); end
      tick();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
    #1;
    n_tests++; if (outstandingCnt !== 3'd0) begin n_fail++; $display("FAIL mixed_cnt0 got %0d exp 0", outstandingCnt); end
  endtask

  task automatic test_unexpected();
    m_r_valid = 1'b1; m_r_last = 1'b1; dmd_r_ready = 1'b0; pf_r_ready = 1'b0;
    #1;
    n_tests++; if (m_r_ready !== 1'b1 || dmd_r_valid !== 1'b0 || pf_r_valid !== 1'b0) begin n_fail++; $display("FAIL unexp_drop got rdy %0b d%0b p%0b exp 1/0/0", m_r_ready, dmd_r_valid, pf_r_valid); end
    tick();
    m_r_valid = 1'b0;
    #1;
    n_tests++; if (errUnexpectedR !== 1'b1) begin n_fail++; $display("FAIL unexp_err got %0b exp 1", errUnexpectedR); end
    tick(); tick();
    n_tests++; if (errUnexpectedR !== 1'b1) begin n_fail++; $display("FAIL unexp_sticky got %0b exp 1", errUnexpectedR); end
    dmd_r_ready = 1'b1; pf_r_ready = 1'b1;
  endtask

  task automatic test_disable_reset();
    en = 1'b1; m_ar_ready = 1'b0;
    dmd_ar_valid = 1'b1; dmd_ar_addr = 16'h0aaa; dmd_ar_len = 8'd3; dmd_ar_id = 8'd7;
    tick();
    en = 1'b0; dmd_ar_addr = 16'h0bbb; pf_ar_valid = 1'b1; pf_ar_addr = 16'h0ccc;
    #1;
    n_tests++; if (dmd_ar_ready !== 1'b0 || pf_ar_ready !== 1'b0) begin n_fail++; $display("FAIL dis_ready got %0b/%0b exp 0/0", dmd_ar_ready, pf_ar_ready); end
    m_ar_ready = 1'b1;
    #1;
    n_tests++; if (dmd_ar_ready !== 1'b0 || pf_ar_ready !== 1'b0) begin n_fail++; $display("FAIL dis_ready_free got %0b/%0b exp 0/0", dmd_ar_ready, pf_ar_ready); end
    m_ar_ready = 1'b0;
    tick(); tick();
    n_tests++; if (m_ar_valid !== 1'b1 || m_ar_addr !== 16'h0aaa || outstandingCnt !== 3'd1) begin n_fail++; $display("FAIL dis_hold got v%0b a%0h c%0d exp 1/0aaa/1", m_ar_valid, m_ar_addr, outstandingCnt); end
    dmd_ar_valid = 1'b0; pf_ar_valid = 1'b0;
    m_r_valid = 1'b1; m_r_last = 1'b0; m_r_data = 8'h55;
    #1;
    n_tests++; if (dmd_r_valid !== 1'b1 || dmd_r_data !== 8'h55) begin n_fail++; $display("FAIL dis_r_drain got %0b/%0h exp 1/55", dmd_r_valid, dmd_r_data); end
    tick();
    resetN = 1'b0;
    tick();
    n_tests++; if (m_ar_valid !== 1'b0 || m_ar_addr !== 16'h0 || m_ar_len !== 8'h0 || m_ar_id !== 8'h0) begin n_fail++; $display("FAIL rst_ar got v%0b a%0h l%0d i%0d exp all 0", m_ar_valid, m_ar_addr, m_ar_len, m_ar_id); end
    n_tests++; if (outstandingCnt !== 3'd0 || errUnexpectedR !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_err got %0d/%0b exp 0/0", outstandingCnt, errUnexpectedR); end
    n_tests++; if (dmd_r_valid !== 1'b0 || pf_r_valid !== 1'b0 || m_r_ready !== 1'b0 || dmd_r_data !== 8'h0) begin n_fail++; $display("FAIL rst_r got d%0b p%0b rdy%0b data %0h exp 0", dmd_r_valid, pf_r_valid, m_r_ready, dmd_r_data); end
    resetN = 1'b1;
    tick();
    n_tests++; if (dmd_r_valid !== 1'b0 || m_r_ready !== 1'b1) begin n_fail++; $display("FAIL rst_tags_gone got d%0b rdy%0b exp 0/1", dmd_r_valid, m_r_ready); end
    m_r_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_demand();
    test_starvation();
    test_fill_stall();
    test_mixed_routing();
    test_unexpected();
    test_disable_reset();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
